cr_rst_seq: RTL and testbench

Parametrised reset sequencer for the CPU subsystem. It takes NUM_DOM per-domain active-low reset requests from pads, synchronises them, and releases the domain resets in strict ascending index order with a programmable gap between releases. Re-assertion of any released domain immediately re-asserts that domain and every higher-indexed domain. It sits between the pad reset pins and the cpuclk-domain consumers, which include core, HAD, and bus fabric. The existing test-mode reset bypass is preserved.

---
 rtl/cr_rst_seq.sv | 117 +++++++++++
 tb/tb_cr_rst_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/cr_rst_seq.sv
// Reset sequencer: synchronises per-domain pad reset requests and releases the
// domain resets in ascending order with a fixed gap. Optional macro: CR_RST_SEQ_SWRST_EN.
module cr_rst_seq #(
  parameter int NUM_DOM  = 3,
  parameter int SYNC_STG = 2,
  parameter int REL_DLY  = 16,
  parameter int CNT_W    = 8
) (
  input  logic               forever_cpuclk,
  input  logic               cpurst,
  input  logic [NUM_DOM-1:0] pad_dom_rst_b,
  input  logic               pad_yy_test_mode,
  input  logic               pad_test_rst_b,
`ifdef CR_RST_SEQ_SWRST_EN
  input  logic               sw_rst_req,
`endif
  output logic [NUM_DOM-1:0] dom_rst_b,
  output logic               seq_busy,
  output logic [3:0]         seq_ptr
);

  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(REL_DLY - 1);
  localparam logic [3:0]       LP_PTR_DONE = 4'(NUM_DOM);

  logic [SYNC_STG-1:0][NUM_DOM-1:0] r_sync;
  logic [NUM_DOM-1:0]               r_relMask;
  logic [3:0]                       r_ptr;
  logic [CNT_W-1:0]                 r_cnt;
  state_t                           r_state;

  logic [NUM_DOM-1:0] w_sync;
  logic               w_failHit;
  logic [3:0]         w_failIdx;
  logic [NUM_DOM-1:0] w_keepMask;
  logic [NUM_DOM-1:0] w_ptrOneHot;
  logic               w_syncAtPtr;
  logic               w_swRst;

`ifdef CR_RST_SEQ_SWRST_EN
  assign w_swRst = sw_rst_req;
`else
  assign w_swRst = 1'b0;
`endif

  assign w_sync = r_sync[SYNC_STG-1];

  // Lowest released domain whose request dropped; everything at or above it is re-asserted.
  always_comb begin
    w_failHit   = 1'b0;
    w_failIdx   = '0;
    w_keepMask  = '0;
    w_ptrOneHot = '0;
    w_syncAtPtr = 1'b0;
    for (int i = NUM_DOM - 1; i >= 0; i--) begin
      if (r_relMask[i] && !w_sync[i]) begin
        w_failHit = 1'b1;
        w_failIdx = 4'(i);
      end
    end
    for (int i = 0; i < NUM_DOM; i++) begin
      w_keepMask[i] = (4'(i) < w_failIdx);
      if (r_ptr == 4'(i)) begin
        w_ptrOneHot[i] = 1'b1;
        w_syncAtPtr    = w_sync[i];
      end
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      r_sync    <= '0;
      r_relMask <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_state   <= ST_WAIT;
    end else begin
      r_sync <= {r_sync[SYNC_STG-2:0], pad_dom_rst_b};
      if (w_swRst) begin
        r_relMask <= '0;
        r_ptr     <= '0;
        r_cnt     <= '0;
        r_state   <= ST_WAIT;
      end else if (w_failHit) begin
        r_relMask <= r_relMask & w_keepMask;
        r_ptr     <= w_failIdx;
        r_cnt     <= '0;
        r_state   <= ST_WAIT;
      end else if (r_state == ST_WAIT) begin
        if (r_ptr == LP_PTR_DONE) begin
          r_state <= ST_RUN;
        end else if (w_syncAtPtr) begin
          if (r_cnt == LP_CNT_LAST) begin
            r_relMask <= r_relMask | w_ptrOneHot;
            r_ptr     <= r_ptr + 4'd1;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end else begin
          // A held request stalls the sequence; higher domains stay asserted.
          r_cnt <= '0;
        end
      end
    end
  end

  // Test-mode bypass is purely combinational; the sequencer keeps running beneath it.
  assign dom_rst_b = pad_yy_test_mode ? {NUM_DOM{pad_test_rst_b}} : r_relMask;
  assign seq_busy  = (r_state == ST_WAIT);
  assign seq_ptr   = r_ptr;

endmodule

// File: tb/tb_cr_rst_seq.sv
// Self-checking bench for cr_rst_seq (NUM_DOM=3, SYNC_STG=2, REL_DLY=4).
// Define CR_RST_SEQ_SWRST_EN to also exercise the software reset pulse.
module tb_cr_rst_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] pads;
  logic       testMode;
  logic       testRst;
  logic       swRstReq;
  logic [2:0] domRstB;
  logic       seqBusy;
  logic [3:0] seqPtr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rstIn;
    logic [2:0] padsIn;
    logic       tmIn;
    logic       trstIn;
    int         adv;
    logic [2:0] expDom;
    logic       expBusy;
    logic [3:0] expPtr;
  } vec_t;

  vec_t vecs[$];

  cr_rst_seq #(
    .NUM_DOM (3),
    .SYNC_STG(2),
    .REL_DLY (4),
    .CNT_W   (8)
  ) dut (
    .forever_cpuclk  (clk),
    .cpurst          (rst),
    .pad_dom_rst_b   (pads),
    .pad_yy_test_mode(testMode),
    .pad_test_rst_b  (testRst),
`ifdef CR_RST_SEQ_SWRST_EN
    .sw_rst_req      (swRstReq),
`endif
    .dom_rst_b       (domRstB),
    .seq_busy        (seqBusy),
    .seq_ptr         (seqPtr)
  );

  always #5 clk = ~clk;

  // Drive inputs, then advance the given number of edges, ending 1 time unit past the edge.
  task automatic applyStimulus(input logic r, input logic [2:0] p, input logic tm,
                               input logic tr, input int adv);
    rst      = r;
    pads     = p;
    testMode = tm;
    testRst  = tr;
    if (adv == 0) begin
      #1;
    end else begin
      repeat (adv) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [2:0] eDom,
                             input logic eBusy, input logic [3:0] ePtr);
    checks++;
    if (domRstB !== eDom) begin
      errors++;
      $display("[TB] FAIL %s dom_rst_b got %b want %b", tag, domRstB, eDom);
    end
    checks++;
    if (seqBusy !== eBusy) begin
      errors++;
      $display("[TB] FAIL %s seq_busy got %b want %b", tag, seqBusy, eBusy);
    end
    checks++;
    if (seqPtr !== ePtr) begin
      errors++;
      $display("[TB] FAIL %s seq_ptr got %0d want %0d", tag, seqPtr, ePtr);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [2:0] p, input logic tm,
                              input logic tr, input int adv, input logic [2:0] d,
                              input logic b, input logic [3:0] q);
    vec_t v;
    v.rstIn   = r;
    v.padsIn  = p;
    v.tmIn    = tm;
    v.trstIn  = tr;
    v.adv     = adv;
    v.expDom  = d;
    v.expBusy = b;
    v.expPtr  = q;
    return v;
  endfunction

  initial begin
    rst      = 1'b1;
    pads     = 3'b111;
    testMode = 1'b0;
    testRst  = 1'b0;
    swRstReq = 1'b0;

    // Power-up release staircase
    vecs.push_back(mk(1, 3'b111, 0, 0, 2, 3'b000, 1, 4'd0));
    vecs.push_back(mk(0, 3'b111, 0, 0, 5, 3'b000, 1, 4'd0));
    vecs.push_back(mk(0, 3'b111, 0, 0, 1, 3'b001, 1, 4'd1));
    vecs.push_back(mk(0, 3'b111, 0, 0, 3, 3'b001, 1, 4'd1));
    vecs.push_back(mk(0, 3'b111, 0, 0, 1, 3'b011, 1, 4'd2));
    vecs.push_back(mk(0, 3'b111, 0, 0, 4, 3'b111, 1, 4'd3));
    vecs.push_back(mk(0, 3'b111, 0, 0, 1, 3'b111, 0, 4'd3));
    // Test-mode bypass
    vecs.push_back(mk(0, 3'b111, 1, 0, 0, 3'b000, 0, 4'd3));
    vecs.push_back(mk(0, 3'b111, 1, 1, 0, 3'b111, 0, 4'd3));
    vecs.push_back(mk(0, 3'b111, 1, 0, 1, 3'b000, 0, 4'd3));
    vecs.push_back(mk(0, 3'b111, 0, 0, 0, 3'b111, 0, 4'd3));
    // Simultaneous fails on domains 0 and 2
    vecs.push_back(mk(0, 3'b010, 0, 0, 2, 3'b111, 0, 4'd3));
    vecs.push_back(mk(0, 3'b010, 0, 0, 1, 3'b000, 1, 4'd0));
    vecs.push_back(mk(0, 3'b111, 0, 0, 5, 3'b000, 1, 4'd0));
    vecs.push_back(mk(0, 3'b111, 0, 0, 1, 3'b001, 1, 4'd1));
    vecs.push_back(mk(0, 3'b111, 0, 0, 4, 3'b011, 1, 4'd2));
    // Test mode over a running sequence leaves the release mask untouched
    vecs.push_back(mk(0, 3'b111, 1, 1, 2, 3'b111, 1, 4'd2));
    vecs.push_back(mk(0, 3'b111, 0, 1, 0, 3'b011, 1, 4'd2));
    // cpurst mid-sequence
    vecs.push_back(mk(1, 3'b111, 0, 0, 1, 3'b000, 1, 4'd0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rstIn, vecs[i].padsIn, vecs[i].tmIn, vecs[i].trstIn, vecs[i].adv);
      checkOutput($sformatf("vec%0d", i), vecs[i].expDom, vecs[i].expBusy, vecs[i].expPtr);
    end

    $display("[TB] stalled domain sequence");
    applyStimulus(1, 3'b101, 0, 0, 1);
    applyStimulus(0, 3'b101, 0, 0, 6);
    checkOutput("stall_d0", 3'b001, 1, 4'd1);
    applyStimulus(0, 3'b101, 0, 0, 10);
    checkOutput("stall_hold", 3'b001, 1, 4'd1);
    applyStimulus(0, 3'b111, 0, 0, 5);
    checkOutput("stall_pre", 3'b001, 1, 4'd1);
    applyStimulus(0, 3'b111, 0, 0, 1);
    checkOutput("stall_d1", 3'b011, 1, 4'd2);
    applyStimulus(0, 3'b111, 0, 0, 4);
    checkOutput("stall_d2", 3'b111, 1, 4'd3);
    applyStimulus(0, 3'b111, 0, 0, 1);
    checkOutput("stall_done", 3'b111, 0, 4'd3);

    $display("[TB] mid-run fail on domain 1");
    applyStimulus(0, 3'b101, 0, 0, 2);
    checkOutput("fail_lat", 3'b111, 0, 4'd3);
    applyStimulus(0, 3'b101, 0, 0, 1);
    checkOutput("fail_hit", 3'b001, 1, 4'd1);
    applyStimulus(0, 3'b111, 0, 0, 5);
    checkOutput("fail_pre", 3'b001, 1, 4'd1);
    applyStimulus(0, 3'b111, 0, 0, 1);
    checkOutput("fail_d1", 3'b011, 1, 4'd2);
    applyStimulus(0, 3'b111, 0, 0, 4);
    checkOutput("fail_d2", 3'b111, 1, 4'd3);
    applyStimulus(0, 3'b111, 0, 0, 1);
    checkOutput("fail_done", 3'b111, 0, 4'd3);

`ifdef CR_RST_SEQ_SWRST_EN
    $display("[TB] software reset pulse");
    swRstReq = 1'b1;
    applyStimulus(0, 3'b111, 0, 0, 1);
    swRstReq = 1'b0;
    checkOutput("sw_hit", 3'b000, 1, 4'd0);
    applyStimulus(0, 3'b111, 0, 0, 3);
    checkOutput("sw_pre", 3'b000, 1, 4'd0);
    applyStimulus(0, 3'b111, 0, 0, 1);
    checkOutput("sw_d0", 3'b001, 1, 4'd1);
    applyStimulus(0, 3'b111, 0, 0, 4);
    checkOutput("sw_d1", 3'b011, 1, 4'd2);
    applyStimulus(1, 3'b111, 0, 0, 1);
    checkOutput("sw_cpurst", 3'b000, 1, 4'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
